// File: rtl/aes_stream_pkg.sv
// Shared definitions for the AES word-serial stream front/back end.
//   BLK_W          : cipher block width in bits
//   state_t / St*  : FSM encoding for aes_word_stream_if
//   words_per_blk  : stream words needed to fill one BLK_W block
package aes_stream_pkg;

  localparam int unsigned BLK_W = 128;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StLdKey  = 3'd1;
  localparam state_t StLdText = 3'd2;
  localparam state_t StFire   = 3'd3;
  localparam state_t StWait   = 3'd4;
  localparam state_t StDrain  = 3'd5;

  function automatic int unsigned words_per_blk(input int unsigned dw);
    return BLK_W / dw;
  endfunction

endpackage

// File: rtl/aes_word_shifter.sv
// BLK_W-bit word shift register with a word counter.
//   clk, rst   : clock, asynchronous active-low reset
//   clr        : synchronous clear of data and count (highest priority)
//   blk_load   : parallel load of blk_in, count cleared
//   load_word  : shift word_in in at the LS end, count advances
//   shift_word : shift one word out of the MS end (zero fill), count advances
//   word_in    : DW-bit word to shift in
//   blk_in     : BLK_W-bit parallel load value
//   blk        : register contents
//   count      : words moved so far, wraps to 0 after BLK_W/DW words
module aes_word_shifter #(
  parameter int unsigned DW    = 32,
  parameter int unsigned BLK_W = 128
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             blk_load,
  input  logic                             load_word,
  input  logic                             shift_word,
  input  logic [DW-1:0]                    word_in,
  input  logic [BLK_W-1:0]                 blk_in,
  output logic [BLK_W-1:0]                 blk,
  output logic [$clog2(BLK_W/DW)-1:0]      count
);

  localparam int unsigned NW = BLK_W / DW;
  localparam int unsigned CW = $clog2(NW);

  logic [BLK_W-1:0] blk_q, blk_d;
  logic [CW-1:0]    count_q, count_d, count_nxt;

  // Wrapping lets a completed block leave the count at 0 for the next frame.
  assign count_nxt = (count_q == CW'(NW - 1)) ? '0 : count_q + 1'b1;

  always_comb begin
    blk_d   = blk_q;
    count_d = count_q;
    if (clr) begin
      blk_d   = '0;
      count_d = '0;
    end else if (blk_load) begin
      blk_d   = blk_in;
      count_d = '0;
    end else if (load_word) begin
      blk_d   = {blk_q[BLK_W-DW-1:0], word_in};
      count_d = count_nxt;
    end else if (shift_word) begin
      blk_d   = {blk_q[BLK_W-DW-1:0], {DW{1'b0}}};
      count_d = count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_q   <= '0;
      count_q <= '0;
    end else begin
      blk_q   <= blk_d;
      count_q <= count_d;
    end
  end

  assign blk   = blk_q;
  assign count = count_q;

endmodule

// File: rtl/aes_word_stream_if.sv
// Word-serial front/back end for the AES cipher datapath.
// Assembles key/plaintext blocks from a DW-bit valid/ready stream, issues a one-cycle ld to
// the cipher, captures its result on done and streams it back out MS word first.
//   clk, rst                      : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     : input word stream
//   in_key                        : first word of frame: 1 = key+text frame, 0 = text only
//   ld, key, text_in              : cipher load strobe and operands
//   done, text_out                : cipher result pulse and value
//   out_valid/out_ready/out_data  : output word stream, out_last marks the final word
//   busy                          : not idle
//   nokey                         : sticky, a text-only frame fired with no key loaded
module aes_word_stream_if
  import aes_stream_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            in_key,
  output logic            ld,
  output logic [127:0]    key,
  output logic [127:0]    text_in,
  input  logic            done,
  input  logic [127:0]    text_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic            busy,
  output logic            nokey
);

  localparam int unsigned NW = words_per_blk(DW);
  localparam int unsigned CW = $clog2(NW);

  state_t state_q, state_d;
  logic   key_loaded_q, key_loaded_d;
  logic   nokey_q, nokey_d;

  logic          in_hs, out_hs;
  logic          key_load, text_load, res_load;
  logic [CW-1:0] key_cnt, text_cnt, res_cnt;
  logic          key_last, text_last, res_last;
  logic [127:0]  result_blk;

  assign in_ready = (state_q == StIdle) || (state_q == StLdKey) || (state_q == StLdText);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  assign key_load  = in_hs && (((state_q == StIdle) && in_key) || (state_q == StLdKey));
  assign text_load = in_hs && (((state_q == StIdle) && !in_key) || (state_q == StLdText));
  // done is only meaningful while waiting on the cipher.
  assign res_load  = (state_q == StWait) && done;

  assign key_last  = (key_cnt == CW'(NW - 1));
  assign text_last = (text_cnt == CW'(NW - 1));
  assign res_last  = (res_cnt == CW'(NW - 1));

  aes_word_shifter #(
    .DW    (DW),
    .BLK_W (BLK_W)
  ) u_key_sr (
    .clk        (clk),
    .rst        (rst),
    .clr        (1'b0),
    .blk_load   (1'b0),
    .load_word  (key_load),
    .shift_word (1'b0),
    .word_in    (in_data),
    .blk_in     ('0),
    .blk        (key),
    .count      (key_cnt)
  );

  aes_word_shifter #(
    .DW    (DW),
    .BLK_W (BLK_W)
  ) u_text_sr (
    .clk        (clk),
    .rst        (rst),
    .clr        (1'b0),
    .blk_load   (1'b0),
    .load_word  (text_load),
    .shift_word (1'b0),
    .word_in    (in_data),
    .blk_in     ('0),
    .blk        (text_in),
    .count      (text_cnt)
  );

  aes_word_shifter #(
    .DW    (DW),
    .BLK_W (BLK_W)
  ) u_result_sr (
    .clk        (clk),
    .rst        (rst),
    .clr        (1'b0),
    .blk_load   (res_load),
    .load_word  (1'b0),
    .shift_word (out_hs),
    .word_in    ('0),
    .blk_in     (text_out),
    .blk        (result_blk),
    .count      (res_cnt)
  );

  always_comb begin
    state_d      = state_q;
    key_loaded_d = key_loaded_q;
    nokey_d      = nokey_q;
    case (state_q)
      StIdle: begin
        if (in_hs) state_d = in_key ? StLdKey : StLdText;
      end
      StLdKey: begin
        if (key_load && key_last) begin
          state_d      = StLdText;
          key_loaded_d = 1'b1;
        end
      end
      StLdText: begin
        if (text_load && text_last) state_d = StFire;
      end
      StFire: begin
        state_d = StWait;
        // The block still fires with whatever the key register holds.
        if (!key_loaded_q) nokey_d = 1'b1;
      end
      StWait: begin
        if (done) state_d = StDrain;
      end
      StDrain: begin
        if (out_hs && res_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      key_loaded_q <= 1'b0;
      nokey_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_loaded_q <= key_loaded_d;
      nokey_q      <= nokey_d;
    end
  end

  assign ld        = (state_q == StFire);
  assign out_valid = (state_q == StDrain);
  assign out_data  = result_blk[127 -: DW];
  assign out_last  = out_valid && res_last;
  assign busy      = (state_q != StIdle);
  assign nokey     = nokey_q;

  // Lower result bits only leave through the shifter, never directly.
  logic unused_result_lo;
  assign unused_result_lo = ^result_blk[127-DW:0];

endmodule

// File: tb/tb_aes_word_stream_if.sv
// Scoreboard bench: DW=32 instance for the main sequences, DW=8 instance for the byte build.
module tb_aes_word_stream_if;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct packed {
    logic [127:0] k;
    logic [127:0] t;
  } ld_exp_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } out_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DW = 32 instance
  logic         in_valid32, in_ready32, in_key32, ld32, done32, out_valid32, out_ready32;
  logic         out_last32, busy32, nokey32, model_done32, spurious_done32;
  logic [31:0]  in_data32, out_data32;
  logic [127:0] key32, text_in32, text_out32;
  assign done32 = model_done32 | spurious_done32;

  // DW = 8 instance
  logic         in_valid8, in_ready8, in_key8, ld8, done8, out_valid8, out_ready8;
  logic         out_last8, busy8, nokey8;
  logic [7:0]   in_data8, out_data8;
  logic [127:0] key8, text_in8, text_out8;

  aes_word_stream_if #(.DW(32)) u_dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .in_data   (in_data32),
    .in_key    (in_key32),
    .ld        (ld32),
    .key       (key32),
    .text_in   (text_in32),
    .done      (done32),
    .text_out  (text_out32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .out_data  (out_data32),
    .out_last  (out_last32),
    .busy      (busy32),
    .nokey     (nokey32)
  );

  aes_word_stream_if #(.DW(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_data   (in_data8),
    .in_key    (in_key8),
    .ld        (ld8),
    .key       (key8),
    .text_in   (text_in8),
    .done      (done8),
    .text_out  (text_out8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_data  (out_data8),
    .out_last  (out_last8),
    .busy      (busy8),
    .nokey     (nokey8)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  ld_exp_t  ld_q32[$];
  ld_exp_t  ld_q8[$];
  out_exp_t exp_q32[$];
  out_exp_t exp_q8[$];
  logic [127:0] model_key32, model_key8;
  logic last_word32, last_word8;
  logic ld_due32, ld_due8, in_locked32;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    model_key32 = '0;
    model_key8  = '0;
    step();
    rst = 1'b1;
  endtask

  // ---------------- DW = 32 stimulus ----------------
  task automatic send_word32(input logic [31:0] data, input logic k, input logic last,
                             input bit gap);
    int n;
    if (gap) repeat ($urandom_range(0, 3)) step();
    in_valid32  = 1'b1;
    in_data32   = data;
    in_key32    = k;
    last_word32 = last;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready32) break;
      n++;
      if (n >= 200) begin
        check_eq("in32_ready_timeout", in_ready32, 1'b1);
        break;
      end
    end
    step();
    in_valid32  = 1'b0;
    last_word32 = 1'b0;
  endtask

  task automatic send_frame32(input bit key_frame, input bit gap);
    ld_q32.push_back('{k: key_frame ? FIPS_KEY : model_key32, t: FIPS_PT});
    if (key_frame) model_key32 = FIPS_KEY;
    for (int i = 0; i < 4; i++) exp_q32.push_back('{data: 64'(FIPS_CT[127-32*i -: 32]), last: i == 3});
    if (key_frame)
      for (int i = 0; i < 4; i++)
        send_word32(FIPS_KEY[127-32*i -: 32], (i == 0) ? 1'b1 : 1'($urandom), 1'b0, gap);
    for (int i = 0; i < 4; i++)
      send_word32(FIPS_PT[127-32*i -: 32], (!key_frame && i == 0) ? 1'b0 : 1'($urandom),
                  i == 3, gap);
  endtask

  task automatic wait_idle32();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_q32.size() == 0 && !busy32) break;
      n++;
      if (n >= 400) break;
    end
    check_eq("drain32_busy", busy32, 1'b0);
    check_eq("drain32_queue", exp_q32.size(), 0);
    step();
  endtask

  // ---------------- DW = 8 stimulus ----------------
  task automatic send_word8(input logic [7:0] data, input logic k, input logic last);
    int n;
    in_valid8  = 1'b1;
    in_data8   = data;
    in_key8    = k;
    last_word8 = last;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready8) break;
      n++;
      if (n >= 200) begin
        check_eq("in8_ready_timeout", in_ready8, 1'b1);
        break;
      end
    end
    step();
    in_valid8  = 1'b0;
    last_word8 = 1'b0;
  endtask

  task automatic send_frame8();
    ld_q8.push_back('{k: FIPS_KEY, t: FIPS_PT});
    model_key8 = FIPS_KEY;
    for (int i = 0; i < 16; i++) exp_q8.push_back('{data: 64'(FIPS_CT[127-8*i -: 8]), last: i == 15});
    for (int i = 0; i < 16; i++)
      send_word8(FIPS_KEY[127-8*i -: 8], (i == 0) ? 1'b1 : 1'($urandom), 1'b0);
    for (int i = 0; i < 16; i++)
      send_word8(FIPS_PT[127-8*i -: 8], 1'($urandom), i == 15);
  endtask

  task automatic wait_idle8();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_q8.size() == 0 && !busy8) break;
      n++;
      if (n >= 600) break;
    end
    check_eq("drain8_busy", busy8, 1'b0);
    check_eq("drain8_queue", exp_q8.size(), 0);
    step();
  endtask

  // ---------------- cipher stubs ----------------
  initial begin
    model_done32 = 1'b0;
    text_out32   = '0;
    forever begin
      @(negedge clk);
      if (rst && ld32) begin
        repeat (3) step();
        model_done32 = 1'b1;
        text_out32   = FIPS_CT;
        step();
        model_done32 = 1'b0;
        text_out32   = '0;
        @(negedge clk);
        check_eq("out32_valid_after_done", out_valid32, 1'b1);
      end
    end
  end

  initial begin
    done8     = 1'b0;
    text_out8 = '0;
    forever begin
      @(negedge clk);
      if (rst && ld8) begin
        repeat (2) step();
        done8     = 1'b1;
        text_out8 = FIPS_CT;
        step();
        done8     = 1'b0;
        text_out8 = '0;
      end
    end
  end

  // ---------------- monitors / scoreboard ----------------
  initial begin
    ld_exp_t e;
    ld_due32    = 1'b0;
    in_locked32 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ld_due32    = 1'b0;
        in_locked32 = 1'b0;
      end else begin
        check_eq("ld32_timing", ld32, ld_due32);
        ld_due32 = in_valid32 && in_ready32 && last_word32;
        if (ld32) begin
          in_locked32 = 1'b1;
          if (ld_q32.size() == 0) check_eq("ld32_unexpected", ld32, 1'b0);
          else begin
            e = ld_q32.pop_front();
            check_eq("ld32_key", key32, e.k);
            check_eq("ld32_text", text_in32, e.t);
          end
        end
        if (in_locked32) check_eq("in_ready32_locked", in_ready32, 1'b0);
        if (out_valid32) begin
          if (exp_q32.size() == 0) check_eq("out32_unexpected", out_valid32, 1'b0);
          else begin
            check_eq("out32_data", out_data32, exp_q32[0].data);
            check_eq("out32_last", out_last32, exp_q32[0].last);
            if (out_ready32) begin
              if (exp_q32[0].last) in_locked32 = 1'b0;
              void'(exp_q32.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    ld_exp_t e;
    ld_due8 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) ld_due8 = 1'b0;
      else begin
        check_eq("ld8_timing", ld8, ld_due8);
        ld_due8 = in_valid8 && in_ready8 && last_word8;
        if (ld8) begin
          if (ld_q8.size() == 0) check_eq("ld8_unexpected", ld8, 1'b0);
          else begin
            e = ld_q8.pop_front();
            check_eq("ld8_key", key8, e.k);
            check_eq("ld8_text", text_in8, e.t);
          end
        end
        if (out_valid8) begin
          if (exp_q8.size() == 0) check_eq("out8_unexpected", out_valid8, 1'b0);
          else begin
            check_eq("out8_data", out_data8, exp_q8[0].data);
            check_eq("out8_last", out_last8, exp_q8[0].last);
            if (out_ready8) void'(exp_q8.pop_front());
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst = 1'b0;
    in_valid32 = 1'b0; in_data32 = '0; in_key32 = 1'b0; out_ready32 = 1'b1;
    in_valid8  = 1'b0; in_data8  = '0; in_key8  = 1'b0; out_ready8  = 1'b1;
    spurious_done32 = 1'b0;
    last_word32 = 1'b0; last_word8 = 1'b0;
    model_key32 = '0; model_key8 = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready32, 1'b1);
    check_eq("rst_ld", ld32, 1'b0);
    check_eq("rst_out_valid", out_valid32, 1'b0);
    check_eq("rst_out_last", out_last32, 1'b0);
    check_eq("rst_busy", busy32, 1'b0);
    check_eq("rst_nokey", nokey32, 1'b0);
    check_eq("rst_key", key32, '0);
    check_eq("rst_text_in", text_in32, '0);
    check_eq("rst_in_ready8", in_ready8, 1'b1);
    check_eq("rst_busy8", busy8, 1'b0);
    step();
    rst = 1'b1;
    step();

    // Text-only frame straight after reset: fires with key 0, raises sticky nokey
    send_frame32(1'b0, 1'b0);
    wait_idle32();
    check_eq("nokey_set", nokey32, 1'b1);
    repeat (3) step();
    check_eq("nokey_sticky", nokey32, 1'b1);

    do_reset();
    @(negedge clk);
    check_eq("nokey_cleared", nokey32, 1'b0);
    step();

    // FIPS-197 key + text frame
    send_frame32(1'b1, 1'b0);
    wait_idle32();
    check_eq("fips_nokey", nokey32, 1'b0);
    check_eq("fips_key_held", key32, FIPS_KEY);

    // Key reuse
    send_frame32(1'b0, 1'b0);
    wait_idle32();
    check_eq("reuse_nokey", nokey32, 1'b0);
    check_eq("reuse_key", key32, FIPS_KEY);

    // Backpressure on the 2nd output word plus random input gaps
    send_frame32(1'b0, 1'b1);
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid32) break;
      n++;
      if (n >= 200) begin
        check_eq("bp_out_valid_timeout", out_valid32, 1'b1);
        break;
      end
    end
    step();
    out_ready32 = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check_eq("bp_stall_data", out_data32, FIPS_CT[95:64]);
    check_eq("bp_stall_in_ready", in_ready32, 1'b0);
    step();
    repeat (2) step();
    out_ready32 = 1'b1;
    wait_idle32();

    // Reset after 3 of 8 words, then a full frame
    for (int i = 0; i < 3; i++) send_word32(FIPS_KEY[127-32*i -: 32], i == 0, 1'b0, 1'b1);
    do_reset();
    @(negedge clk);
    check_eq("midrst_busy", busy32, 1'b0);
    check_eq("midrst_in_ready", in_ready32, 1'b1);
    check_eq("midrst_key", key32, '0);
    step();
    send_frame32(1'b1, 1'b1);
    wait_idle32();

    // Spurious done in IDLE
    spurious_done32 = 1'b1;
    step();
    spurious_done32 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("spurious_out_valid", out_valid32, 1'b0);
      check_eq("spurious_busy", busy32, 1'b0);
    end
    step();

    // DW = 8 build with the FIPS vector
    send_frame8();
    wait_idle8();
    check_eq("dw8_key_held", key8, FIPS_KEY);
    check_eq("dw8_nokey", nokey8, 1'b0);
    check_eq("dw8_ld_queue", ld_q8.size(), 0);
    check_eq("dw32_ld_queue", ld_q32.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
